// File: rtl/udma_hyper_sched_pkg.sv
// Shared types for the HyperBus channel scheduler: FSM states and the latched descriptor.
// Descriptor fields are sized for the widest supported bus (HADDR_W <= 32, TRANS_SIZE <= 16).
package udma_hyper_sched_pkg;

    localparam int SCHED_TIMEOUT_W = 16;
    localparam int DESC_ADDR_W     = 32;
    localparam int DESC_SIZE_W     = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_EOT   = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] addr;
        logic [DESC_SIZE_W-1:0] size;
        logic                   rwn;
        logic                   cs;
    } hyper_desc_t;

endpackage

// File: rtl/udma_hyper_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo NB_CH.
module udma_hyper_rr_arb #(
    parameter int NB_CH = 8
) (
    input  logic [NB_CH-1:0]         req_i,
    input  logic [$clog2(NB_CH)-1:0] ptr_i,
    output logic [NB_CH-1:0]         gnt_o,
    output logic [$clog2(NB_CH)-1:0] idx_o,
    output logic                     any_o
);

    localparam int IDX_W = $clog2(NB_CH);

    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path can infer a latch.
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < NB_CH; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NB_CH);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udma_hyper_ch_sched.sv
// Round-robin scheduler sharing one HyperBus transaction engine between NB_CH channels.
// Optional BUSY watchdog is compiled in with `define UDMA_HYPER_SCHED_TIMEOUT_EN.
module udma_hyper_ch_sched
    import udma_hyper_sched_pkg::*;
#(
    parameter int NB_CH      = 8,
    parameter int TRANS_SIZE = 16,
    parameter int HADDR_W    = 32
) (
    input  logic                             sys_clk_i,
    input  logic                             rstn_i,
    input  logic [NB_CH-1:0]                 ch_req_i,
    output logic [NB_CH-1:0]                 ch_gnt_o,
    input  logic [NB_CH-1:0][HADDR_W-1:0]    ch_addr_i,
    input  logic [NB_CH-1:0][TRANS_SIZE-1:0] ch_size_i,
    input  logic [NB_CH-1:0]                 ch_rwn_i,
    input  logic [NB_CH-1:0]                 ch_cs_i,
    output logic                             trans_valid_o,
    input  logic                             trans_ready_i,
    output logic [HADDR_W-1:0]               trans_addr_o,
    output logic [TRANS_SIZE-1:0]            trans_size_o,
    output logic                             trans_rwn_o,
    output logic                             trans_cs_o,
    output logic [$clog2(NB_CH)-1:0]         trans_id_o,
    input  logic                             trans_done_i,
    output logic [NB_CH-1:0]                 evt_eot_o,
`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
    input  logic [SCHED_TIMEOUT_W-1:0]       timeout_cycles_i,
    output logic [NB_CH-1:0]                 evt_timeout_o,
`endif
    output logic                             busy_o
);

    localparam int IDX_W = $clog2(NB_CH);

    sched_state_e     state_q, state_d;
    hyper_desc_t      desc_q, desc_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             done_seen_q, done_seen_d;

    logic [NB_CH-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic             desc_zero;
    logic             handshake;
    logic             engine_done;
    logic             timeout_hit;

    udma_hyper_rr_arb #(
        .NB_CH (NB_CH)
    ) i_rr_arb (
        .req_i (ch_req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign desc_zero   = (desc_q.size == '0);
    assign handshake   = (state_q == S_ISSUE) && !desc_zero && trans_ready_i;
    // A done that coincided with the ready handshake is carried into BUSY via done_seen_q.
    assign engine_done = done_seen_q || trans_done_i;

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            desc_q      <= '0;
            id_q        <= '0;
            ptr_q       <= '0;
            done_seen_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            desc_q      <= desc_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            done_seen_q <= done_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        desc_d      = desc_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        done_seen_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    state_d     = S_ISSUE;
                    desc_d.addr = DESC_ADDR_W'(ch_addr_i[arb_idx]);
                    desc_d.size = DESC_SIZE_W'(ch_size_i[arb_idx]);
                    desc_d.rwn  = ch_rwn_i[arb_idx];
                    desc_d.cs   = ch_cs_i[arb_idx];
                    id_d        = arb_idx;
                    ptr_d       = (arb_idx == IDX_W'(NB_CH - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            S_ISSUE: begin
                // Zero-byte descriptors never reach the engine.
                if (desc_zero) begin
                    state_d = S_EOT;
                end else if (handshake) begin
                    state_d     = S_BUSY;
                    done_seen_d = trans_done_i;
                end
            end
            S_BUSY: begin
                if (engine_done || timeout_hit) begin
                    state_d = S_EOT;
                end
            end
            S_EOT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ch_gnt_o  = '0;
        evt_eot_o = '0;
        // Grant is held off while reset is asserted so every output reads 0 during reset.
        if ((state_q == S_IDLE) && rstn_i) begin
            ch_gnt_o = arb_gnt;
        end
        if (state_q == S_EOT) begin
            evt_eot_o[id_q] = 1'b1;
        end
    end

    assign trans_valid_o = (state_q == S_ISSUE) && !desc_zero;
    assign busy_o        = (state_q != S_IDLE);
    assign trans_addr_o  = desc_q.addr[HADDR_W-1:0];
    assign trans_size_o  = desc_q.size[TRANS_SIZE-1:0];
    assign trans_rwn_o   = desc_q.rwn;
    assign trans_cs_o    = desc_q.cs;
    assign trans_id_o    = id_q;

`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
    logic [SCHED_TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (handshake) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_BUSY) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // A done arriving on the expiry cycle wins; a zero limit disables the watchdog.
    assign timeout_hit = (state_q == S_BUSY) && !engine_done &&
                         (timeout_cycles_i != '0) && (tmo_cnt_q == timeout_cycles_i);

    always_comb begin
        evt_timeout_o = '0;
        if (timeout_hit) begin
            evt_timeout_o[id_q] = 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_udma_hyper_ch_sched.sv
// Directed, table-driven bench for udma_hyper_ch_sched (NB_CH=8); timeout checks follow
// UDMA_HYPER_SCHED_TIMEOUT_EN.
module tb_udma_hyper_ch_sched;

    localparam int NB_CH      = 8;
    localparam int TRANS_SIZE = 16;
    localparam int HADDR_W    = 32;
    localparam int IDX_W      = 3;

    logic                             clk = 1'b0;
    logic                             rstn;
    logic [NB_CH-1:0]                 ch_req;
    logic [NB_CH-1:0]                 ch_gnt;
    logic [NB_CH-1:0][HADDR_W-1:0]    ch_addr;
    logic [NB_CH-1:0][TRANS_SIZE-1:0] ch_size;
    logic [NB_CH-1:0]                 ch_rwn;
    logic [NB_CH-1:0]                 ch_cs;
    logic                             trans_valid;
    logic                             trans_ready;
    logic [HADDR_W-1:0]               trans_addr;
    logic [TRANS_SIZE-1:0]            trans_size;
    logic                             trans_rwn;
    logic                             trans_cs;
    logic [IDX_W-1:0]                 trans_id;
    logic                             trans_done;
    logic [NB_CH-1:0]                 evt_eot;
    logic                             busy;
`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
    logic [15:0]                      timeout_cycles;
    logic [NB_CH-1:0]                 evt_timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  req;
        logic [31:0] addr;
        logic [15:0] size;
        logic        rwn;
        logic        cs;
        int          ready_lat;
        int          done_lat;
        logic [7:0]  exp_gnt;
        logic [2:0]  exp_id;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    udma_hyper_ch_sched #(
        .NB_CH      (NB_CH),
        .TRANS_SIZE (TRANS_SIZE),
        .HADDR_W    (HADDR_W)
    ) dut (
        .sys_clk_i        (clk),
        .rstn_i           (rstn),
        .ch_req_i         (ch_req),
        .ch_gnt_o         (ch_gnt),
        .ch_addr_i        (ch_addr),
        .ch_size_i        (ch_size),
        .ch_rwn_i         (ch_rwn),
        .ch_cs_i          (ch_cs),
        .trans_valid_o    (trans_valid),
        .trans_ready_i    (trans_ready),
        .trans_addr_o     (trans_addr),
        .trans_size_o     (trans_size),
        .trans_rwn_o      (trans_rwn),
        .trans_cs_o       (trans_cs),
        .trans_id_o       (trans_id),
        .trans_done_i     (trans_done),
        .evt_eot_o        (evt_eot),
`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
        .timeout_cycles_i (timeout_cycles),
        .evt_timeout_o    (evt_timeout),
`endif
        .busy_o           (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bg_fill();
        for (int i = 0; i < NB_CH; i++) begin
            ch_addr[i] = 32'hA000_0000 + 32'(i);
            ch_size[i] = 16'h0100 + 16'(i);
            ch_rwn[i]  = (i % 2) == 1;
            ch_cs[i]   = (i % 4) >= 2;
        end
    endtask

    // One full transaction, entered at a falling edge with the scheduler idle.
    task automatic do_txn(input logic [7:0] req, input logic [31:0] addr, input logic [15:0] size,
                          input logic rwn, input logic cs, input int ready_lat, input int done_lat,
                          input logic [7:0] exp_gnt, input logic [2:0] exp_id, input string tag);
        ch_addr[exp_id] = addr;
        ch_size[exp_id] = size;
        ch_rwn[exp_id]  = rwn;
        ch_cs[exp_id]   = cs;
        ch_req          = req;
        trans_ready     = 1'b0;
        trans_done      = 1'b0;
        #1;
        check({tag, "_gnt"}, 64'(ch_gnt), 64'(exp_gnt));
        @(negedge clk);
        ch_req = req & ~exp_gnt;
        #1;
        check({tag, "_valid"}, {ch_gnt, trans_valid}, {8'h00, 1'b1});
        check({tag, "_desc"}, {trans_addr, trans_size, trans_rwn, trans_cs, trans_id},
              {addr, size, rwn, cs, exp_id});
        for (int j = 0; j < ready_lat; j++) begin
            @(negedge clk);
            #1;
            check({tag, "_hold"}, {trans_valid, trans_addr, trans_size, trans_id},
                  {1'b1, addr, size, exp_id});
        end
        trans_ready = 1'b1;
        @(negedge clk);
        trans_ready = 1'b0;
        #1;
        check({tag, "_busy"}, {busy, trans_valid}, 2'b10);
        for (int j = 0; j < done_lat; j++) begin
            @(negedge clk);
            #1;
            check({tag, "_wait"}, {evt_eot, busy}, {8'h00, 1'b1});
        end
        trans_done = 1'b1;
        @(negedge clk);
        trans_done = 1'b0;
        #1;
        check({tag, "_eot"}, 64'(evt_eot), 64'(exp_gnt));
        ch_req = '0;
        @(negedge clk);
        #1;
        check({tag, "_idle"}, {evt_eot, busy}, 9'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] exp;
        int         seen;

        // Pointer starts at 1 here (the fairness run ends on channel 0).
        vecs[0] = '{8'h04, 32'h0000_1000, 16'd64,  1'b1, 1'b0, 0, 10, 8'h04, 3'd2};
        vecs[1] = '{8'h03, 32'h0000_2000, 16'd128, 1'b0, 1'b1, 5, 2,  8'h01, 3'd0};
        vecs[2] = '{8'h03, 32'h0000_3000, 16'd4,   1'b1, 1'b1, 1, 0,  8'h02, 3'd1};
        vecs[3] = '{8'h21, 32'h0000_4000, 16'd32,  1'b0, 1'b0, 0, 3,  8'h20, 3'd5};
        vecs[4] = '{8'hC0, 32'h0000_5000, 16'd2,   1'b1, 1'b0, 2, 1,  8'h40, 3'd6};
        vecs[5] = '{8'h81, 32'h0000_6000, 16'd8,   1'b0, 1'b1, 0, 0,  8'h80, 3'd7};
        vecs[6] = '{8'h81, 32'h0000_7000, 16'd1,   1'b1, 1'b0, 0, 1,  8'h01, 3'd0};

        rstn        = 1'b0;
        ch_req      = 8'hFF;
        trans_ready = 1'b0;
        trans_done  = 1'b0;
`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
        timeout_cycles = 16'd0;
`endif
        bg_fill();

        @(negedge clk);
        #1;
        check("reset_ctrl", {ch_gnt, evt_eot, trans_valid, busy, trans_id}, 0);
        check("reset_desc", {trans_addr, trans_size, trans_rwn, trans_cs}, 0);
        ch_req = '0;
        rstn   = 1'b1;
        @(negedge clk);

        // Fairness: all channels requesting, grants walk 0..7 then wrap to 0.
        for (int i = 0; i < 9; i++) begin
            exp = 8'h01 << (i % 8);
            do_txn(8'hFF, 32'hF000_0000 + 32'(i), 16'd16 + 16'(i), (i % 2) == 1, 1'b0,
                   0, 1, exp, 3'(i % 8), $sformatf("rr%0d", i));
        end

        for (int v = 0; v < 7; v++) begin
            do_txn(vecs[v].req, vecs[v].addr, vecs[v].size, vecs[v].rwn, vecs[v].cs,
                   vecs[v].ready_lat, vecs[v].done_lat, vecs[v].exp_gnt, vecs[v].exp_id,
                   $sformatf("vec%0d", v));
        end

        // Done pulses while idle and while waiting for ready must be ignored.
        trans_done = 1'b1;
        @(negedge clk);
        trans_done = 1'b0;
        #1;
        check("ign_idle", {busy, evt_eot}, 9'd0);
        ch_req = 8'h02;
        #1;
        check("ign_gnt", 64'(ch_gnt), 64'h02);
        @(negedge clk);
        ch_req     = '0;
        trans_done = 1'b1;
        @(negedge clk);
        trans_done  = 1'b0;
        trans_ready = 1'b1;
        #1;
        check("ign_issue", {trans_valid, busy, evt_eot}, {1'b1, 1'b1, 8'h00});
        @(negedge clk);
        trans_ready = 1'b0;
        repeat (3) begin
            #1;
            check("ign_busy", {evt_eot, busy, trans_valid}, {8'h00, 1'b1, 1'b0});
            @(negedge clk);
        end
        trans_done = 1'b1;
        @(negedge clk);
        trans_done = 1'b0;
        #1;
        check("ign_eot", 64'(evt_eot), 64'h02);
        @(negedge clk);

        // Done in the same cycle as the ready handshake: EOT one cycle after BUSY entry.
        ch_req = 8'h20;
        #1;
        check("same_gnt", 64'(ch_gnt), 64'h20);
        @(negedge clk);
        ch_req      = '0;
        trans_ready = 1'b1;
        trans_done  = 1'b1;
        #1;
        check("same_issue", {trans_valid, trans_id}, {1'b1, 3'd5});
        @(negedge clk);
        trans_ready = 1'b0;
        trans_done  = 1'b0;
        #1;
        check("same_busy", {evt_eot, busy, trans_valid}, {8'h00, 1'b1, 1'b0});
        @(negedge clk);
        #1;
        check("same_eot", 64'(evt_eot), 64'h20);
        @(negedge clk);
        #1;
        check("same_idle", {evt_eot, busy}, 9'd0);

        // Zero-size descriptor on channel 3: no valid, eot two cycles after grant.
        ch_size[3] = 16'd0;
        ch_req     = 8'h08;
        #1;
        check("zero_gnt", 64'(ch_gnt), 64'h08);
        @(negedge clk);
        ch_req = '0;
        #1;
        check("zero_issue", {trans_valid, evt_eot, busy, trans_id, trans_size}, {1'b0, 8'h00, 1'b1, 3'd3, 16'd0});
        @(negedge clk);
        #1;
        check("zero_eot", {trans_valid, evt_eot}, {1'b0, 8'h08});
        @(negedge clk);
        #1;
        check("zero_idle", {trans_valid, evt_eot, busy}, 10'd0);
        ch_size[3] = 16'h0103;

        // Reset while BUSY on channel 4: everything clears, no eot, pointer back to 0.
        ch_req = 8'h10;
        #1;
        check("rst_gnt", 64'(ch_gnt), 64'h10);
        @(negedge clk);
        ch_req      = '0;
        trans_ready = 1'b1;
        @(negedge clk);
        trans_ready = 1'b0;
        #1;
        check("rst_busy", {busy, trans_id}, {1'b1, 3'd4});
        @(negedge clk);
        ch_req = 8'h21;
        rstn   = 1'b0;
        #1;
        check("rst_ctrl", {busy, trans_valid, ch_gnt, evt_eot, trans_id}, 0);
        check("rst_desc", {trans_addr, trans_size, trans_rwn, trans_cs}, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_no_eot", {evt_eot, ch_gnt, busy}, 0);
        end
        rstn = 1'b1;
        do_txn(8'h21, 32'h0000_2100, 16'd8, 1'b0, 1'b1, 0, 0, 8'h01, 3'd0, "post_rst");

`ifdef UDMA_HYPER_SCHED_TIMEOUT_EN
        // Engine never completes: watchdog fires when the BUSY counter reaches 20.
        timeout_cycles = 16'd20;
        ch_req = 8'h40;
        #1;
        check("tmo_gnt", 64'(ch_gnt), 64'h40);
        @(negedge clk);
        ch_req      = '0;
        trans_ready = 1'b1;
        @(negedge clk);
        trans_ready = 1'b0;
        seen = -1;
        exp  = '0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (evt_timeout != '0) begin
                seen = k;
                exp  = evt_timeout;
                check("tmo_no_eot_yet", 64'(evt_eot), 64'h00);
                break;
            end
            @(negedge clk);
        end
        check("tmo_cycle", 64'(seen), 64'd20);
        check("tmo_evt", 64'(exp), 64'h40);
        @(negedge clk);
        #1;
        check("tmo_eot", {evt_eot, evt_timeout}, {8'h40, 8'h00});
        @(negedge clk);
        #1;
        check("tmo_idle", {evt_eot, busy}, 9'd0);
        timeout_cycles = 16'd0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
